// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM for the multi-cycle RV32I core
//
// Sequences the shared ALU, the unified memory port and the register file
// through fetch / decode / execute / memory / writeback.
//
// Ports:
//   clk, rst_n        core clock (rising edge), synchronous active-low reset
//   opcode[6:0]       instr[6:0] from the instruction register
//   mem_ready         memory access completes this cycle
//   branch_taken      ALU compare result for the current branch
//   pc_write          PC load enable
//   ir_write          instruction / old-PC register load enable
//   adr_src           memory address select (0 = PC, 1 = ALUOut)
//   mem_read          memory read strobe
//   mem_write         memory write strobe
//   reg_write         register file write enable
//   alu_src_a[1:0]    ALU A select (PC, oldPC, rs1, zero)
//   alu_src_b[1:0]    ALU B select (rs2, imm, const 4)
//   alu_op[1:0]       ALU operation class (add, branch compare, funct decode)
//   result_src[1:0]   result select (ALUOut, mem data, ALU result)
//   illegal           sticky: unsupported opcode or memory timeout
//   state_o[3:0]      current state encoding for debug
//
// MEM_WAIT_MAX bounds the cycles spent waiting on mem_ready in a memory
// state; 0 disables the bound.

module multicycle_controller #(
    parameter int unsigned MEM_WAIT_MAX = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       illegal,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEMADR    = 4'd3,
        S_MEMREAD   = 4'd4,
        S_MEMWB     = 4'd5,
        S_MEMWRITE  = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALUWB     = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR      = 4'd12,
        S_JALR_LINK = 4'd13,
        S_LUI       = 4'd14,
        S_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] wait_cnt;
    logic        illegal_q;
    logic        waiting;
    logic        timeout;

    // A memory-port state that is stalled this cycle.
    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                   (state_q == S_MEMWRITE)) && !mem_ready;
    end

    // wait_cnt holds the stalled cycles already spent in this state, so the
    // current cycle is number wait_cnt + 1.
    always_comb begin
        timeout = waiting && (MEM_WAIT_MAX != 0) &&
                  ((wait_cnt + 32'd1) >= MEM_WAIT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:    state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:     state_d = S_FETCH;
            S_MEMWRITE:  if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_ALUWB;
            S_EXEC_I:    state_d = S_ALUWB;
            S_ALUWB:     state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALUWB;
            S_JALR:      state_d = S_JALR_LINK;
            S_JALR_LINK: state_d = S_ALUWB;
            S_LUI:       state_d = S_ALUWB;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_TRAP;
        endcase
        if (timeout) begin
            state_d = S_TRAP;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into the PC as the
                // instruction lands in IR.
                mem_read   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                // Precompute oldPC + imm into ALUOut for branch / AUIPC.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                // Target is already in ALUOut from DECODE.
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = branch_taken;
            end
            S_JAL: begin
                // Loads the DECODE target from ALUOut while computing
                // oldPC + 4 for the link.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_JALR_LINK: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
            end
            default: begin
            end
        endcase
    end

    assign illegal = illegal_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    logic       pc_write, ir_write, adr_src, mem_read, mem_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state_o;

    logic       w_pc_write, w_ir_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write, w_illegal;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;
    logic [3:0] w_state_o;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .result_src(result_src), .illegal(illegal), .state_o(state_o)
    );

    multicycle_controller #(.MEM_WAIT_MAX(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(w_pc_write), .ir_write(w_ir_write),
        .adr_src(w_adr_src), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .reg_write(w_reg_write), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .alu_op(w_alu_op), .result_src(w_result_src), .illegal(w_illegal), .state_o(w_state_o)
    );

    localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3;
    localparam int ST_MEMREAD = 4, ST_MEMWB = 5, ST_MEMWRITE = 6, ST_EXEC_R = 7;
    localparam int ST_EXEC_I = 8, ST_ALUWB = 9, ST_BRANCH = 10, ST_JAL = 11;
    localparam int ST_JALR = 12, ST_JALR_LINK = 13, ST_LUI = 14, ST_TRAP = 15;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_BAD = 7'b1111111;

    typedef struct packed {
        logic       pcw, irw, adr, mrd, mwr, rw;
        logic [1:0] a, b, aop, rs;
        logic       ill;
    } outs_t;

    typedef struct {
        logic [6:0] op;
        logic       mr, bt;
        int         st;
        logic       pcw, rw;
        logic [1:0] aop;
    } vec_t;

    typedef struct {
        int   st;
        logic mr, bt;
    } step_t;

    int    checks = 0;
    int    failures = 0;
    vec_t  vecs[$];
    step_t steps[$];

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output table straight from the per-state description.
    function automatic outs_t exp_out(int st, logic mr, logic bt);
        outs_t o;
        o = '0;
        case (st)
            ST_FETCH:     begin o.mrd = 1; o.b = 2'b10; o.rs = 2'b10; o.irw = mr; o.pcw = mr; end
            ST_DECODE:    begin o.a = 2'b01; o.b = 2'b01; end
            ST_MEMADR:    begin o.a = 2'b10; o.b = 2'b01; end
            ST_MEMREAD:   begin o.mrd = 1; o.adr = 1; end
            ST_MEMWB:     begin o.rs = 2'b01; o.rw = 1; end
            ST_MEMWRITE:  begin o.mwr = 1; o.adr = 1; end
            ST_EXEC_R:    begin o.a = 2'b10; o.aop = 2'b10; end
            ST_EXEC_I:    begin o.a = 2'b10; o.b = 2'b01; o.aop = 2'b10; end
            ST_ALUWB:     begin o.rw = 1; end
            ST_BRANCH:    begin o.a = 2'b10; o.aop = 2'b01; o.pcw = bt; end
            ST_JAL:       begin o.a = 2'b01; o.b = 2'b10; o.pcw = 1; end
            ST_JALR:      begin o.a = 2'b10; o.b = 2'b01; o.rs = 2'b10; o.pcw = 1; end
            ST_JALR_LINK: begin o.a = 2'b01; o.b = 2'b10; end
            ST_LUI:       begin o.a = 2'b11; o.b = 2'b01; end
            ST_TRAP:      begin o.ill = 1; end
            default:      begin end
        endcase
        return o;
    endfunction

    function automatic outs_t dut_outs();
        return {pc_write, ir_write, adr_src, mem_read, mem_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal};
    endfunction

    function automatic outs_t w_outs();
        return {w_pc_write, w_ir_write, w_adr_src, w_mem_read, w_mem_write, w_reg_write,
                w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src, w_illegal};
    endfunction

    task automatic addv(logic [6:0] op, logic mr, logic bt, int st, logic pcw, logic rw, logic [1:0] aop);
        vec_t v;
        v.op = op; v.mr = mr; v.bt = bt; v.st = st; v.pcw = pcw; v.rw = rw; v.aop = aop;
        vecs.push_back(v);
    endtask

    // A memory-port state stalled for w cycles, then completing.
    task automatic add_wait(int st, int w);
        step_t s;
        for (int i = 0; i < w; i++) begin
            s.st = st; s.mr = 1'b0; s.bt = 1'($urandom);
            steps.push_back(s);
        end
        s.st = st; s.mr = 1'b1; s.bt = 1'($urandom);
        steps.push_back(s);
    endtask

    task automatic add_plain(int st);
        step_t s;
        s.st = st; s.mr = 1'($urandom); s.bt = 1'($urandom);
        steps.push_back(s);
    endtask

    initial begin
        logic [6:0] legal_ops[9];
        logic [6:0] cur_op;
        outs_t      eo;

        legal_ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

        // R-type, stalled load, taken / not-taken branch, JALR, illegal opcode
        addv(OP_R, 1, 0, ST_RESET,     0, 0, 2'b00);
        addv(OP_R, 1, 0, ST_FETCH,     1, 0, 2'b00);
        addv(OP_R, 1, 0, ST_DECODE,    0, 0, 2'b00);
        addv(OP_R, 1, 0, ST_EXEC_R,    0, 0, 2'b10);
        addv(OP_R, 1, 0, ST_ALUWB,     0, 1, 2'b00);
        addv(OP_LOAD, 1, 0, ST_FETCH,  1, 0, 2'b00);
        addv(OP_LOAD, 1, 0, ST_DECODE, 0, 0, 2'b00);
        addv(OP_LOAD, 1, 0, ST_MEMADR, 0, 0, 2'b00);
        addv(OP_LOAD, 0, 0, ST_MEMREAD, 0, 0, 2'b00);
        addv(OP_LOAD, 0, 0, ST_MEMREAD, 0, 0, 2'b00);
        addv(OP_LOAD, 0, 0, ST_MEMREAD, 0, 0, 2'b00);
        addv(OP_LOAD, 1, 0, ST_MEMREAD, 0, 0, 2'b00);
        addv(OP_LOAD, 1, 0, ST_MEMWB,  0, 1, 2'b00);
        addv(OP_BR, 1, 0, ST_FETCH,    1, 0, 2'b00);
        addv(OP_BR, 1, 1, ST_DECODE,   0, 0, 2'b00);
        addv(OP_BR, 1, 1, ST_BRANCH,   1, 0, 2'b01);
        addv(OP_BR, 1, 0, ST_FETCH,    1, 0, 2'b00);
        addv(OP_BR, 1, 0, ST_DECODE,   0, 0, 2'b00);
        addv(OP_BR, 1, 0, ST_BRANCH,   0, 0, 2'b01);
        addv(OP_JALR, 1, 0, ST_FETCH,  1, 0, 2'b00);
        addv(OP_JALR, 1, 0, ST_DECODE, 0, 0, 2'b00);
        addv(OP_JALR, 1, 0, ST_JALR,   1, 0, 2'b00);
        addv(OP_JALR, 1, 0, ST_JALR_LINK, 0, 0, 2'b00);
        addv(OP_JALR, 1, 0, ST_ALUWB,  0, 1, 2'b00);
        addv(OP_BAD, 1, 0, ST_FETCH,   1, 0, 2'b00);
        addv(OP_BAD, 1, 0, ST_DECODE,  0, 0, 2'b00);
        for (int i = 0; i < 10; i++) addv(OP_BAD, 1, 1, ST_TRAP, 0, 0, 2'b00);

        rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b1; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_state", int'(state_o), ST_RESET);
        chk("reset_outs", int'(dut_outs()), 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = 1'b1;
            opcode = vecs[i].op; mem_ready = vecs[i].mr; branch_taken = vecs[i].bt;
            #1;
            chk($sformatf("vec%0d_state", i), int'(state_o), vecs[i].st);
            chk($sformatf("vec%0d_pc_write", i), int'(pc_write), int'(vecs[i].pcw));
            chk($sformatf("vec%0d_reg_write", i), int'(reg_write), int'(vecs[i].rw));
            chk($sformatf("vec%0d_alu_op", i), int'(alu_op), int'(vecs[i].aop));
            chk($sformatf("vec%0d_outs", i), int'(dut_outs()),
                int'(exp_out(vecs[i].st, vecs[i].mr, vecs[i].bt)));
        end

        // One reset edge leaves TRAP and clears the sticky flag.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("trap_reset_state", int'(state_o), ST_RESET);
        chk("trap_reset_illegal", int'(illegal), 0);
        chk("trap_reset_outs", int'(dut_outs()), 0);
        chk("trap_reset_illegal_w", int'(w_illegal), 0);

        // Fetch timeout with MEM_WAIT_MAX = 4.
        rst_n = 1'b1; mem_ready = 1'b0; opcode = OP_R;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            chk($sformatf("to_wait%0d_state", i), int'(w_state_o), ST_FETCH);
            chk($sformatf("to_wait%0d_irw", i), int'(w_ir_write), 0);
        end
        @(negedge clk);
        #1;
        chk("to_trap_state", int'(w_state_o), ST_TRAP);
        chk("to_trap_outs", int'(w_outs()), int'(exp_out(ST_TRAP, 0, 0)));
        chk("to_unlimited_state", int'(state_o), ST_FETCH);
        chk("to_unlimited_illegal", int'(illegal), 0);

        // Same, but memory answers on the 4th waiting cycle.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            mem_ready = (i == 4);
            #1;
            chk($sformatf("ok_wait%0d_state", i), int'(w_state_o), ST_FETCH);
            chk($sformatf("ok_wait%0d_irw", i), int'(w_ir_write), (i == 4) ? 1 : 0);
        end
        @(negedge clk);
        #1;
        chk("ok_decode_state", int'(w_state_o), ST_DECODE);
        chk("ok_decode_illegal", int'(w_illegal), 0);

        // Random instruction stream against a per-instruction state-path model.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rnd_reset_state", int'(state_o), ST_RESET);
        for (int n = 0; n < 150; n++) begin
            cur_op = legal_ops[$urandom_range(0, 8)];
            steps.delete();
            add_wait(ST_FETCH, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            add_plain(ST_DECODE);
            case (cur_op)
                OP_LOAD:  begin add_plain(ST_MEMADR); add_wait(ST_MEMREAD, $urandom_range(0, 3)); add_plain(ST_MEMWB); end
                OP_STORE: begin add_plain(ST_MEMADR); add_wait(ST_MEMWRITE, $urandom_range(0, 3)); end
                OP_R:     begin add_plain(ST_EXEC_R); add_plain(ST_ALUWB); end
                OP_I:     begin add_plain(ST_EXEC_I); add_plain(ST_ALUWB); end
                OP_BR:    add_plain(ST_BRANCH);
                OP_JAL:   begin add_plain(ST_JAL); add_plain(ST_ALUWB); end
                OP_JALR:  begin add_plain(ST_JALR); add_plain(ST_JALR_LINK); add_plain(ST_ALUWB); end
                OP_LUI:   begin add_plain(ST_LUI); add_plain(ST_ALUWB); end
                default:  add_plain(ST_ALUWB);
            endcase
            foreach (steps[k]) begin
                @(negedge clk);
                opcode = cur_op; mem_ready = steps[k].mr; branch_taken = steps[k].bt;
                #1;
                eo = exp_out(steps[k].st, steps[k].mr, steps[k].bt);
                chk($sformatf("rnd%0d_%0d_state", n, k), int'(state_o), steps[k].st);
                chk($sformatf("rnd%0d_%0d_outs", n, k), int'(dut_outs()), int'(eo));
                chk($sformatf("rnd%0d_%0d_state_w", n, k), int'(w_state_o), steps[k].st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences one shared ALU, one unified instruction/data memory port and the register file through fetch, decode, execute, memory and writeback.
- Drives the 2-bit ALU-operation class consumed by the ALU decoder:
  - 00 = add
  - 01 = branch compare
  - 10 = R/I funct decode
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
- MEM_WAIT_MAX, 0, maximum cycles allowed waiting for mem_ready in a memory state. 0 = unlimited. Exceeding the limit enters TRAP.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- opcode  input  7  instr[6:0] from the instruction register.
- mem_ready  input  1  memory access completes this cycle.
- branch_taken  input  1  ALU compare result for the current branch.
- pc_write  output  1  PC register load enable.
- ir_write  output  1  instruction and old-PC register load enable.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write enable.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4.
- alu_op  output  2  ALU-operation class, driven to the ALU decoder.
- result_src  output  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- illegal  output  1  sticky: unsupported opcode or memory timeout.
- state_o  output  4  current state encoding, for debug.

Behaviour:
- Moore FSM with a 4-bit state register, clocked on clk.
- Outputs are decoded from the state register only. Exceptions: ir_write, pc_write and branch gating also use mem_ready or branch_taken, as noted per state.
- Every output not listed for a state is 0.
- Reset:
  - rst_n sampled low forces state RESET (0) and clears illegal and the wait counter.
  - In RESET all outputs are 0.
  - The first cycle after rst_n is sampled high moves to FETCH.
  - Reset mid-instruction aborts the instruction. No write strobe is asserted in the cycle following the reset edge.
- State encodings:
  - RESET = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMREAD = 4, MEMWB = 5
  - MEMWRITE = 6, EXEC_R = 7, EXEC_I = 8, ALUWB = 9, BRANCH = 10, JAL = 11
  - JALR = 12, JALR_LINK = 13, LUI = 14, TRAP = 15
- FETCH:
  - Outputs: mem_read = 1, adr_src = 0, a = 00, b = 10, alu_op = 00, result_src = 10.
  - ir_write = pc_write = mem_ready.
  - Holds while mem_ready = 0; goes to DECODE on mem_ready.
- DECODE:
  - Outputs: a = 01, b = 01, alu_op = 00 (branch/AUIPC target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 -> LUI
    - 0010111 -> ALUWB (AUIPC)
    - anything else -> TRAP
- MEMADR: a = 10, b = 01, alu_op = 00. Goes to MEMREAD if opcode = 0000011, else MEMWRITE.
- MEMREAD: mem_read = 1, adr_src = 1. Holds until mem_ready, then MEMWB.
- MEMWB: result_src = 01, reg_write = 1. Goes to FETCH.
- MEMWRITE: mem_write = 1, adr_src = 1. Holds until mem_ready, then FETCH.
- EXEC_R: a = 10, b = 00, alu_op = 10. Goes to ALUWB.
- EXEC_I: a = 10, b = 01, alu_op = 10. Goes to ALUWB.
- ALUWB: result_src = 00, reg_write = 1. Goes to FETCH.
- BRANCH: a = 10, b = 00, alu_op = 01, result_src = 00, pc_write = branch_taken. Goes to FETCH.
- JAL: a = 01, b = 10, alu_op = 00, result_src = 00, pc_write = 1. Goes to ALUWB (links oldPC+4).
- JALR: a = 10, b = 01, alu_op = 00, result_src = 10, pc_write = 1. Goes to JALR_LINK.
- JALR_LINK: a = 01, b = 10, alu_op = 00. Goes to ALUWB.
- LUI: a = 11, b = 01, alu_op = 00. Goes to ALUWB.
- TRAP: illegal = 1, all strobes 0. Stays in TRAP until reset.
- Wait counter (memory timeout):
  - Counts cycles spent in FETCH, MEMREAD or MEMWRITE with mem_ready = 0.
  - Clears on every state change.
  - If MEM_WAIT_MAX != 0 and the count reaches MEM_WAIT_MAX with mem_ready still 0, the next state is TRAP.
  - mem_ready = 1 in the same cycle as the limit is reached: the access completes normally, no trap.
- Cycle counts with mem_ready tied high:
  - load = 5
  - store, R, I, AUIPC(3), LUI, JAL = 4
  - JALR = 5
  - branch = 3

Test Plan:
- Reset then R-type add (opcode 0110011), mem_ready = 1 -> state_o 0, 1, 2, 7, 9, 1. reg_write = 1 only in state 9. alu_op = 10 in state 7.
- Load (0000011) with mem_ready low for 3 cycles in MEMREAD -> mem_read = 1 and adr_src = 1 held for 4 cycles, then MEMWB with result_src = 01 and reg_write = 1.
- Branch (1100011), branch_taken = 1, then again with branch_taken = 0 -> pc_write = 1 in BRANCH for the first, 0 for the second. alu_op = 01 in both.
- JALR (1100111) -> pc_write = 1 in state 12, then state 13 (a = 01, b = 10), then ALUWB with reg_write = 1.
- Opcode 1111111 -> TRAP: illegal = 1, all strobes 0 for 10 cycles. rst_n low for one edge -> state 0, illegal = 0.
- MEM_WAIT_MAX = 4, mem_ready held 0 in FETCH -> TRAP after the 4th waiting cycle. Repeat with mem_ready = 1 on the 4th cycle -> DECODE, no trap.
